// File: rtl/pipeline_control_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_control_pkg
// Shared definitions for the 5-stage pipeline control slice: opcode constants,
// ALUOp and forward-select encodings, and the packed control bundle that
// travels down the ID/EX, EX/MEM and MEM/WB stage registers.
// ----------------------------------------------------------------------------
package pipeline_control_pkg;

   // Opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALUOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;  // address calc / addi
   localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R-type, ALU decodes funct

   // EX operand-source selects
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
   } ex_ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic branch;
   } mem_ctrl_t;

   typedef struct packed {
      logic mem_to_reg;
      logic reg_write;
   } wb_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } ctrl_t;

   localparam int    CTRL_W   = $bits(ctrl_t);
   localparam ctrl_t CTRL_NOP = '0;

   // rt is read as a source only by these instruction classes; for lw and
   // addi it is the destination, so a match there is not a hazard.
   function automatic logic rt_is_src(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/pipeline_control_decode.sv
// ----------------------------------------------------------------------------
// control_decode
// Purely combinational opcode -> control bundle decode for the ID stage.
// Unknown opcodes decode to an all-zero bundle (NOP).
// Ports:
//   opcode  in   6       instruction[31:26]
//   ctrl    out  CTRL_W  packed ctrl_t bundle (EX, MEM, WB groups)
// ----------------------------------------------------------------------------
module control_decode
   import pipeline_control_pkg::*;
(
   input  logic [5:0]        opcode,
   output logic [CTRL_W-1:0] ctrl
);

   ctrl_t c;

   always_comb begin
      c = CTRL_NOP;
      case (opcode)
         OP_RTYPE: begin
            c.ex.reg_dst   = 1'b1;
            c.ex.alu_op    = ALUOP_FUNCT;
            c.wb.reg_write = 1'b1;
         end
         OP_LW: begin
            c.ex.alu_src    = 1'b1;
            c.ex.alu_op     = ALUOP_ADD;
            c.mem.mem_read  = 1'b1;
            c.wb.mem_to_reg = 1'b1;
            c.wb.reg_write  = 1'b1;
         end
         OP_SW: begin
            c.ex.alu_src    = 1'b1;
            c.ex.alu_op     = ALUOP_ADD;
            c.mem.mem_write = 1'b1;
         end
         OP_BEQ: begin
            c.ex.alu_op  = ALUOP_SUB;
            c.mem.branch = 1'b1;
         end
         OP_ADDI: begin
            c.ex.alu_src   = 1'b1;
            c.ex.alu_op    = ALUOP_ADD;
            c.wb.reg_write = 1'b1;
         end
         default: c = CTRL_NOP;
      endcase
   end

   assign ctrl = c;

endmodule

// File: rtl/pipeline_control.sv
// ----------------------------------------------------------------------------
// pipeline_control
// Control path of a classic 5-stage pipeline: ID decode, ID/EX, EX/MEM and
// MEM/WB control registers, load-use / RAW stall, branch flush and EX operand
// forwarding.
//
// Build option: macro FORWARD_EN.
//   defined   - forwarding from EX/MEM and MEM/WB; only load-use stalls.
//   undefined - no forwarding (selects tied to 00); ID stalls while any
//               in-flight writer targets a live ID source register.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   opcode, rs, rt, rd    fields of the instruction in ID
//   PCSrc                 branch taken (resolved in MEM) -> flush
//   pc_write, ifid_write  PC / IF-ID load enables (0 during a stall)
//   RegDst ALUSrc ALUOp   EX controls, from ID/EX
//   MemRead MemWrite Branch  MEM controls, from EX/MEM
//   MemToReg RegWrite     WB controls, from MEM/WB
//   wb_reg_dest           MEM/WB destination register
//   forward_a, forward_b  EX operand selects (00 RF, 10 EX/MEM, 01 MEM/WB)
// ----------------------------------------------------------------------------
module pipeline_control
   import pipeline_control_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [5:0]            opcode,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  PCSrc,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  RegDst,
   output logic                  ALUSrc,
   output logic [1:0]            ALUOp,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic                  Branch,
   output logic                  MemToReg,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] wb_reg_dest,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b
);

   localparam int W = REG_ADDR_W;

   // ---------------- ID decode ----------------
   logic [CTRL_W-1:0] dec_bits;
   ctrl_t             dec;
   logic [W-1:0]      id_dest;
   logic              rt_live;

   control_decode u_decode (
      .opcode (opcode),
      .ctrl   (dec_bits)
   );

   assign dec     = dec_bits;
   assign id_dest = dec.ex.reg_dst ? rd : rt;
   assign rt_live = rt_is_src(opcode);

   // ---------------- stage registers ----------------
   ctrl_t     idex_ctrl;
   logic [W-1:0] idex_dest;
   mem_ctrl_t exmem_mem;
   wb_ctrl_t  exmem_wb;
   logic [W-1:0] exmem_dest;
   wb_ctrl_t  memwb_wb;
   logic [W-1:0] memwb_dest;

   logic stall, flush, bubble;

   // A writer hits ID when it writes a nonzero register that ID reads.
   function automatic logic src_hit(input logic         we,
                                    input logic [W-1:0] d,
                                    input logic [W-1:0] s,
                                    input logic [W-1:0] t,
                                    input logic         t_live);
      return we && (d != '0) && ((d == s) || (t_live && (d == t)));
   endfunction

   // Flush wins over stall: the PC must take the branch target, so both
   // enables stay high whenever PCSrc is set.
   assign flush      = PCSrc;
   assign pc_write   = flush | ~stall;
   assign ifid_write = flush | ~stall;
   assign bubble     = flush | stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         idex_ctrl  <= CTRL_NOP;
         idex_dest  <= '0;
         exmem_mem  <= '0;
         exmem_wb   <= '0;
         exmem_dest <= '0;
         memwb_wb   <= '0;
         memwb_dest <= '0;
      end else begin
         // Bubble is a full NOP: controls and destination cleared.
         if (bubble) begin
            idex_ctrl <= CTRL_NOP;
            idex_dest <= '0;
         end else begin
            idex_ctrl <= dec;
            idex_dest <= id_dest;
         end

         // Taken branch kills the instruction currently in EX as well.
         if (flush) begin
            exmem_mem  <= '0;
            exmem_wb   <= '0;
            exmem_dest <= '0;
         end else begin
            exmem_mem  <= idex_ctrl.mem;
            exmem_wb   <= idex_ctrl.wb;
            exmem_dest <= idex_dest;
         end

         memwb_wb   <= exmem_wb;
         memwb_dest <= exmem_dest;
      end
   end

`ifdef FORWARD_EN
   // Source addresses are only needed by the forwarding compare.
   logic [W-1:0] idex_rs, idex_rt;

   function automatic logic [1:0] fwd_sel(input logic [W-1:0] src,
                                          input logic         em_we,
                                          input logic [W-1:0] em_d,
                                          input logic         mw_we,
                                          input logic [W-1:0] mw_d);
      // EX/MEM holds the younger result, so it is checked first.
      if (em_we && (em_d != '0) && (em_d == src))      return FWD_EXMEM;
      else if (mw_we && (mw_d != '0) && (mw_d == src)) return FWD_MEMWB;
      else                                             return FWD_RF;
   endfunction

   always_ff @(posedge clock) begin
      if (reset || bubble) begin
         idex_rs <= '0;
         idex_rt <= '0;
      end else begin
         idex_rs <= rs;
         idex_rt <= rt;
      end
   end

   // Only a load in EX cannot be covered by forwarding.
   assign stall = src_hit(idex_ctrl.mem.mem_read, idex_dest, rs, rt, rt_live);

   assign forward_a = fwd_sel(idex_rs, exmem_wb.reg_write, exmem_dest,
                              memwb_wb.reg_write, memwb_dest);
   assign forward_b = fwd_sel(idex_rt, exmem_wb.reg_write, exmem_dest,
                              memwb_wb.reg_write, memwb_dest);
`else
   // Without forwarding ID waits until every pending writer has retired.
   assign stall = src_hit(idex_ctrl.wb.reg_write, idex_dest,  rs, rt, rt_live)
                | src_hit(exmem_wb.reg_write,     exmem_dest, rs, rt, rt_live)
                | src_hit(memwb_wb.reg_write,     memwb_dest, rs, rt, rt_live);

   assign forward_a = FWD_RF;
   assign forward_b = FWD_RF;
`endif

   // ---------------- outputs ----------------
   assign RegDst      = idex_ctrl.ex.reg_dst;
   assign ALUSrc      = idex_ctrl.ex.alu_src;
   assign ALUOp       = idex_ctrl.ex.alu_op;
   assign MemRead     = exmem_mem.mem_read;
   assign MemWrite    = exmem_mem.mem_write;
   assign Branch      = exmem_mem.branch;
   assign MemToReg    = memwb_wb.mem_to_reg;
   assign RegWrite    = memwb_wb.reg_write;
   assign wb_reg_dest = memwb_dest;

endmodule

// File: tb/tb_pipeline_control.sv
// ----------------------------------------------------------------------------
// tb_pipeline_control
// Directed scenarios plus randomized instruction streams, checked against an
// instruction-level model: the pipeline is three slots of whole instructions
// (EX, MEM, WB) and every expected output is derived from which instruction
// sits in which slot.
// ----------------------------------------------------------------------------
module tb_pipeline_control;
   import pipeline_control_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'h3f;
   logic [4:0] rs = '0, rt = '0, rd = '0;
   logic       PCSrc = 1'b0;
   logic       pc_write, ifid_write, RegDst, ALUSrc, MemRead, MemWrite, Branch;
   logic       MemToReg, RegWrite;
   logic [1:0] ALUOp, forward_a, forward_b;
   logic [4:0] wb_reg_dest;

   pipeline_control #(.REG_ADDR_W(5)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
      .PCSrc(PCSrc), .pc_write(pc_write), .ifid_write(ifid_write),
      .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead),
      .MemWrite(MemWrite), .Branch(Branch), .MemToReg(MemToReg),
      .RegWrite(RegWrite), .wb_reg_dest(wb_reg_dest),
      .forward_a(forward_a), .forward_b(forward_b)
   );

   always #5 clock = ~clock;

`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- instruction-level model ----------------
   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rs, rt, rd;
   } ins_t;

   localparam ins_t BUB = '{op: 6'h3f, rs: 5'd0, rt: 5'd0, rd: 5'd0};

   ins_t m_ex, m_mem, m_wb;
   logic s_pcw;
   logic exp_pcw;

   function automatic logic writes(input logic [5:0] op);
      return op == OP_RTYPE || op == OP_LW || op == OP_ADDI;
   endfunction

   function automatic logic [4:0] dst(input ins_t i);
      return (i.op == OP_RTYPE) ? i.rd : i.rt;
   endfunction

   function automatic logic reads_rt(input logic [5:0] op);
      return op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
   endfunction

   function automatic logic hits(input ins_t w, input ins_t id);
      return writes(w.op) && dst(w) != 0 &&
             (dst(w) == id.rs || (reads_rt(id.op) && dst(w) == id.rt));
   endfunction

   function automatic logic m_stall(input ins_t id);
      if (FWD) return m_ex.op == OP_LW && hits(m_ex, id);
      else     return hits(m_ex, id) || hits(m_mem, id) || hits(m_wb, id);
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] r);
      if (!FWD) return 2'b00;
      if (writes(m_mem.op) && dst(m_mem) != 0 && dst(m_mem) == r) return 2'b10;
      if (writes(m_wb.op)  && dst(m_wb)  != 0 && dst(m_wb)  == r) return 2'b01;
      return 2'b00;
   endfunction

   // {RegDst, ALUSrc, ALUOp, MemRead, MemWrite, Branch, MemToReg, RegWrite}
   function automatic logic [9:0] m_ctrl();
      logic [1:0] aop;
      aop = (m_ex.op == OP_RTYPE) ? 2'b10 : (m_ex.op == OP_BEQ) ? 2'b01 : 2'b00;
      return {m_ex.op == OP_RTYPE,
              m_ex.op == OP_LW || m_ex.op == OP_SW || m_ex.op == OP_ADDI, aop,
              m_mem.op == OP_LW, m_mem.op == OP_SW, m_mem.op == OP_BEQ,
              m_wb.op == OP_LW, writes(m_wb.op)};
   endfunction

   function automatic logic [9:0] dut_ctrl();
      return {RegDst, ALUSrc, ALUOp, MemRead, MemWrite, Branch, MemToReg, RegWrite};
   endfunction

   // One clock with the given instruction in ID; outputs checked mid-cycle.
   task automatic cyc(input logic [5:0] op, input logic [4:0] a, b, d, input logic br);
      ins_t id;
      logic st;
      id = '{op: op, rs: a, rt: b, rd: d};
      opcode = op; rs = a; rt = b; rd = d; PCSrc = br;
      @(negedge clock);
      st = m_stall(id);
      exp_pcw = br || !st;
      chk("ctrl", dut_ctrl(), m_ctrl());
      chk("wb_dest", wb_reg_dest, dst(m_wb));
      chk("fwd", {forward_a, forward_b}, {m_fwd(m_ex.rs), m_fwd(m_ex.rt)});
      chk("pc_ifid_write", {pc_write, ifid_write}, {exp_pcw, exp_pcw});
      s_pcw = pc_write;
      @(posedge clock);
      m_wb  = m_mem;
      m_mem = br ? BUB : m_ex;
      m_ex  = (br || st) ? BUB : id;
      #1;
   endtask

   // Reset for a number of edges with whatever is currently in ID, then
   // check the post-reset state with a NOP in ID.
   task automatic do_reset(input int edges);
      reset = 1'b1;
      repeat (edges) @(posedge clock);
      #1;
      reset = 1'b0;
      opcode = 6'h3f; rs = '0; rt = '0; rd = '0; PCSrc = 1'b0;
      m_ex = BUB; m_mem = BUB; m_wb = BUB;
      #1;
      chk("rst_ctrl", dut_ctrl(), 10'd0);
      chk("rst_dest", wb_reg_dest, 5'd0);
      chk("rst_fwd", {forward_a, forward_b}, 4'd0);
      chk("rst_pcw", {pc_write, ifid_write}, 2'b11);
   endtask

   // Re-present one instruction until ID is released; n = stalled cycles.
   task automatic hold(input logic [5:0] op, input logic [4:0] a, b, d, output int n);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         cyc(op, a, b, d, 1'b0);
         if (s_pcw) break;
         n++;
      end
   endtask

   initial begin
      int   n;
      ins_t cur;
      logic hold_id;
      logic br;
      logic [5:0] rop;

      do_reset(2);

      // lw latency through the stages
      cyc(OP_LW, 5'd1, 5'd2, 5'd0, 1'b0);
      chk("lw_ex", {ALUSrc, ALUOp}, 3'b100);
      cyc(6'h3f, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("lw_mem", MemRead, 1'b1);
      cyc(6'h3f, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("lw_wb", {MemToReg, RegWrite}, 2'b11);

      // load-use
      do_reset(1);
      cyc(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0);
      cyc(OP_RTYPE, 5'd5, 5'd6, 5'd7, 1'b0);
      chk("lu_pcw", s_pcw, 1'b0);
      chk("lu_bubble", {RegDst, ALUSrc, ALUOp}, 4'd0);
      hold(OP_RTYPE, 5'd5, 5'd6, 5'd7, n);
      chk("lu_len", n + 1, FWD ? 1 : 3);
      chk("lu_fwd_a", forward_a, FWD ? 2'b01 : 2'b00);

      // two writers of r3, then a reader: youngest wins
      do_reset(1);
      cyc(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
      cyc(OP_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
      hold(OP_RTYPE, 5'd3, 5'd4, 5'd8, n);
      chk("dbl_fwd_a", forward_a, FWD ? 2'b10 : 2'b00);

      // writes to r0 never forward or stall
      do_reset(1);
      cyc(OP_RTYPE, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc(OP_RTYPE, 5'd0, 5'd0, 5'd9, 1'b0);
      chk("r0_pcw", s_pcw, 1'b1);
      chk("r0_fwd_a", forward_a, 2'b00);

      // RAW on r4 with a plain add
      do_reset(1);
      cyc(OP_RTYPE, 5'd1, 5'd2, 5'd4, 1'b0);
      hold(OP_RTYPE, 5'd4, 5'd5, 5'd6, n);
      chk("raw_len", n, FWD ? 0 : 3);
      chk("raw_fwd", {forward_a, forward_b}, FWD ? 4'b1000 : 4'b0000);

      // branch flush
      do_reset(1);
      cyc(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc(OP_ADDI, 5'd1, 5'd3, 5'd0, 1'b0);
      cyc(OP_RTYPE, 5'd1, 5'd2, 5'd4, 1'b1);
      chk("br_pcw", s_pcw, 1'b1);
      chk("br_ex", {RegDst, ALUSrc, ALUOp}, 4'd0);
      chk("br_mem", {MemRead, MemWrite, Branch}, 3'd0);

      // flush together with load-use: flush wins
      do_reset(1);
      cyc(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0);
      cyc(OP_RTYPE, 5'd5, 5'd6, 5'd7, 1'b1);
      chk("br_lu_pcw", s_pcw, 1'b1);

      // reset in the middle of a load-use stall
      do_reset(1);
      cyc(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0);
      opcode = OP_RTYPE; rs = 5'd5; rt = 5'd6; rd = 5'd7;
      #1;
      chk("pre_rst_stall", pc_write, 1'b0);
      do_reset(1);

      // randomized stream; a stalled instruction is re-presented
      hold_id = 1'b0;
      cur = BUB;
      for (int k = 0; k < 800; k++) begin
         if (!hold_id) begin
            rop = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 5))
               0: cur.op = OP_RTYPE;
               1: cur.op = OP_LW;
               2: cur.op = OP_SW;
               3: cur.op = OP_BEQ;
               4: cur.op = OP_ADDI;
               default: cur.op = rop;
            endcase
            cur.rs = 5'($urandom_range(0, 7));
            cur.rt = 5'($urandom_range(0, 7));
            cur.rd = 5'($urandom_range(0, 7));
         end
         br = ($urandom_range(0, 9) == 0);
         cyc(cur.op, cur.rs, cur.rt, cur.rd, br);
         hold_id = !exp_pcw;
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1);
            hold_id = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, width of register-address fields.
REQ-002 clock  in  1  rising-edge clock, single clock domain.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 opcode  in  6  instruction[31:26] of the instruction currently in ID.
REQ-005 rs, rt, rd  in  REG_ADDR_W each  instruction[25:21], [20:16], [15:11] in ID.
REQ-006 PCSrc  in  1  branch taken, resolved in MEM.
REQ-007 pc_write, ifid_write  out  1 each  enables for the PC and IF/ID registers.
REQ-008 RegDst, ALUSrc  out  1 each; ALUOp  out  2  EX-stage controls.
REQ-009 MemRead, MemWrite, Branch  out  1 each  MEM-stage controls.
REQ-010 MemToReg, RegWrite  out  1 each  WB-stage controls.
REQ-011 wb_reg_dest  out  REG_ADDR_W  write-back destination register.
REQ-012 forward_a, forward_b  out  2 each  EX operand-source selects: 00 register file, 10 EX/MEM, 01 MEM/WB.

Function
REQ-013 ID decode:
- 000000 R-type: RegDst=1, ALUOp=10, RegWrite=1.
- 100011 lw: ALUSrc, MemRead, MemToReg, RegWrite = 1; ALUOp=00.
- 101011 sw: ALUSrc, MemWrite = 1; ALUOp=00.
- 000100 beq: Branch=1, ALUOp=01.
- 001000 addi: ALUSrc, RegWrite = 1; ALUOp=00.
- Any other opcode: all controls 0 (NOP).
REQ-014 ID/EX, EX/MEM and MEM/WB control registers advance every rising edge, each adding one cycle of latency. Each stage-output group is driven from its own stage register.
REQ-015 ID/EX also captures rs, rt and the destination (rd if RegDst=1, else rt). The destination then advances to EX/MEM and MEM/WB. wb_reg_dest is the MEM/WB copy.
REQ-016 rt is a source operand only for R-type, sw and beq. Register 0 never causes a hazard or a forward.
REQ-017 Load-use stall: ID/EX.MemRead=1 and ID/EX dest equal to a live ID source.
- Same cycle: pc_write=0, ifid_write=0.
- Next edge: ID/EX loads all-zero controls (bubble).
- Stall lasts exactly one cycle.
REQ-018 Branch flush: when PCSrc=1, the next edge zeroes the IF/ID-derived decode and the ID/EX and EX/MEM controls. MEM/WB advances normally.
REQ-019 Flush has priority over stall when both occur in the same cycle. pc_write=1 so that the branch target loads.
REQ-020 forward_a (forward_b analogous for rt):
- 10 if EX/MEM.RegWrite and EX/MEM dest == ID/EX.rs.
- else 01 if MEM/WB.RegWrite and MEM/WB dest == ID/EX.rs.
- else 00.
- EX/MEM wins when both match.
REQ-021 Stall, forward and flush decisions are combinational from the current stage registers and ID inputs. No extra latency is added.

Reset
REQ-022 While reset=1 at an edge, all stage control registers and captured register addresses clear to 0.
REQ-023 After reset:
- All control outputs, forward selects and wb_reg_dest are 0.
- pc_write=1 and ifid_write=1.
REQ-024 Reset asserted mid-stall or mid-flush discards that operation. There is no resumption after release.

Configuration
REQ-025 Macro FORWARD_EN.
- Defined: REQ-020 applies and only REQ-017 stalls.
- Undefined: forward_a and forward_b are tied to 00. A stall is held (pc_write=0, ifid_write=0, bubble inserted) for as long as ID/EX, EX/MEM or MEM/WB has RegWrite=1 with a nonzero dest matching a live ID source.

Structure
REQ-026 A shared package holds:
- the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI);
- the ALUOp encodings;
- the forward-select encodings;
- a packed control-bundle typedef for the EX, MEM and WB groups.
REQ-027 One sub-module, control_decode, holds the purely combinational opcode-to-bundle decode. Hazard, forwarding and stage registers stay in pipeline_control.

Verification
REQ-028 Decode and latency check: reset, then lw (opcode 100011).
- +1 cycle: ALUSrc=1, ALUOp=00.
- +2 cycles: MemRead=1.
- +3 cycles: MemToReg=1, RegWrite=1.
REQ-029 Load-use: lw dest rt=5, then R-type with rs=5.
- pc_write=0 and ifid_write=0 for exactly 1 cycle.
- Next cycle: the EX controls are all 0.
- FORWARD_EN defined: forward_a=01 when the R-type reaches EX.
REQ-030 Double forward: add to r3, add to r3, then add using r3.
- forward_a=10, not 01.
- A write to r0 gives forward_a=00.
REQ-031 Branch: beq, then assert PCSrc=1 for one cycle.
- Next cycle: ID/EX and EX/MEM controls are 0 and pc_write=1.
- With a simultaneous load-use hazard: pc_write is still 1.
REQ-032 FORWARD_EN undefined: add r4, then add reading r4. The stall holds 3 cycles, then releases; forward selects stay 00.
REQ-033 Reset during a stall: all outputs zero and pc_write=1 on the cycle after reset.
